// File: rtl/cpu_pkg.sv
// Shared types and constants for the 3-stage fetch/execute/writeback core.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    FLUSH  = 2'd2,
    MCWAIT = 2'd3
  } pipe_state_t;
endpackage

// File: rtl/pipe_fwd_cmp.sv
// Writeback-to-execute hazard compare for one source operand; x0 never forwards.
module pipe_fwd_cmp
  import cpu_pkg::*;
(
  input  logic             wb_valid,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [REG_W-1:0] src,
  output logic             fwd
);
  assign fwd = wb_valid & wb_regwrite & (wb_rd != REG_ZERO) & (wb_rd == src);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: PC/fetch address, EX/WB validity, redirect bubble,
// multi-cycle execute stall and WB->EX forwarding selects.
// state  | meaning
// FILL   | first fetch after reset, EX empty
// RUN    | EX live, advancing or launching a multi-cycle op
// FLUSH  | wrong-path instruction in EX killed, target being fetched
// MCWAIT | EX held until the multi-cycle unit reports done
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              PERF_W   = 32
) (
  input  logic              clk,
  input  logic              res,
  input  logic [REG_W-1:0]  ex_rs1,
  input  logic [REG_W-1:0]  ex_rs2,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_multi,
  input  logic              ex_redirect,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              mc_done,
  output logic [XLEN-1:0]   imem_addr,
  output logic [XLEN-1:0]   pc_EX,
  output logic              ex_valid,
  output logic              ex_commit,
  output logic              mc_start,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [REG_W-1:0]  wb_rd,
  output logic [PERF_W-1:0] retired
);
  pipe_state_t     state, state_nxt;
  logic [XLEN-1:0] pc_f, pc_f_nxt, pc_ex_nxt;
  logic            mc_busy, mc_busy_nxt;
  logic            hold;

  always_comb begin
    state_nxt   = state;
    pc_f_nxt    = pc_f;
    pc_ex_nxt   = pc_EX;
    mc_busy_nxt = mc_busy;
    imem_addr   = pc_f;
    ex_valid    = 1'b0;
    ex_commit   = 1'b0;
    mc_start    = 1'b0;
    hold        = 1'b0;
    case (state)
      FILL, FLUSH: begin
        pc_ex_nxt = pc_f;
        pc_f_nxt  = pc_f + XLEN'(INSTR_BYTES);
        state_nxt = RUN;
      end
      RUN, MCWAIT: begin
        ex_valid = 1'b1;
        hold = (state == RUN) ? ex_multi : !(mc_done && mc_busy);
        if (hold) begin
          // Re-read the EX address so the fetch stage keeps presenting it.
          imem_addr = pc_EX;
          if (state == RUN) begin
            mc_start    = 1'b1;
            mc_busy_nxt = 1'b1;
            state_nxt   = MCWAIT;
          end
        end else begin
          ex_commit   = 1'b1;
          mc_busy_nxt = 1'b0;
          if (ex_redirect) begin
            pc_f_nxt  = ex_target & ~XLEN'(3);
            state_nxt = FLUSH;
          end else begin
            pc_ex_nxt = pc_f;
            pc_f_nxt  = pc_f + XLEN'(INSTR_BYTES);
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state       <= FILL;
      pc_f        <= RESET_PC;
      pc_EX       <= RESET_PC;
      mc_busy     <= 1'b0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= REG_ZERO;
      retired     <= '0;
    end else begin
      state       <= state_nxt;
      pc_f        <= pc_f_nxt;
      pc_EX       <= pc_ex_nxt;
      mc_busy     <= mc_busy_nxt;
      wb_valid    <= ex_commit;
      wb_regwrite <= ex_commit & ex_regwrite;
      if (ex_commit) wb_rd <= ex_rd;
      if (wb_valid) retired <= retired + 1'b1;
    end
  end

  pipe_fwd_cmp u_fwd_a (
    .wb_valid    (wb_valid),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .src         (ex_rs1),
    .fwd         (fwd_a)
  );

  pipe_fwd_cmp u_fwd_b (
    .wb_valid    (wb_valid),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .src         (ex_rs2),
    .fwd         (fwd_b)
  );
endmodule
